// File: rtl/mem_xfer_ctrl_pkg.sv
// Shared types and defaults for the pair-summing memory transfer controller.
package mem_xfer_pkg;

    localparam int DW_DEF    = 8;
    localparam int NB_DEF    = 4;
    localparam int SRC_WORDS = 2 * NB_DEF;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RDA  = 3'd1,
        RDB  = 3'd2,
        ADD  = 3'd3,
        WR   = 3'd4,
        DONE = 3'd5
    } state_e;

endpackage

// File: rtl/mem_xfer_ctrl_if.sv
// Handshake plus memory A read port and memory B write port of the transfer controller.
interface mem_xfer_ctrl_if #(
    parameter int DW  = 8,
    parameter int AWA = 3,
    parameter int AWB = 2
);
    logic           start;
    logic           busy;
    logic           done;
    logic           ovf;
    logic [AWA-1:0] AddrA;
    logic [DW-1:0]  DOutA;
    logic [AWB-1:0] AddrB;
    logic           WEB;
    logic [DW-1:0]  DataInB;

    modport master (
        input  start, DOutA,
        output busy, done, ovf, AddrA, AddrB, WEB, DataInB
    );

    modport slave (
        output start, DOutA,
        input  busy, done, ovf, AddrA, AddrB, WEB, DataInB
    );
endinterface

// File: rtl/mem_xfer_ctrl_add.sv
// Combinational DW-bit pair adder; define XFER_SAT_EN to saturate instead of wrap.
// The carry is reported in both builds so overflow tracking does not depend on the mode.
module xfer_add #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] sum,
    output logic          carry
);
    logic [DW:0] full;

    always_comb begin
        full  = {1'b0, a} + {1'b0, b};
        carry = full[DW];
`ifdef XFER_SAT_EN
        sum   = carry ? '1 : full[DW-1:0];
`else
        sum   = full[DW-1:0];
`endif
    end
endmodule

// File: rtl/mem_xfer_ctrl.sv
// Reads memory A in pairs and writes B[i] = A[2i] + A[2i+1]; XFER_SAT_EN selects saturating sums.
module mem_xfer_ctrl
    import mem_xfer_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int NB  = NB_DEF,
    parameter int AWA = $clog2(2 * NB),
    parameter int AWB = $clog2(NB)
) (
    input  logic              clock,
    input  logic              reset_n,
    mem_xfer_ctrl_if.master   bus
);
    state_e         state_q, state_d;
    logic [AWB-1:0] i_q, i_d;
    logic [DW-1:0]  opa_q, opa_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           web_q, web_d;
    logic [AWB-1:0] addr_b_q, addr_b_d;
    logic [DW-1:0]  data_b_q, data_b_d;
    logic           ovf_q, ovf_d;
    logic [AWA-1:0] addr_a;
    logic [DW-1:0]  sum;
    logic           carry;

    xfer_add #(.DW(DW)) u_add (
        .a     (opa_q),
        .b     (bus.DOutA),
        .sum   (sum),
        .carry (carry)
    );

    always_comb begin
        // NOTE: every _d and output gets a default before the case so no path can infer a latch.
        state_d  = state_q;
        i_d      = i_q;
        opa_d    = opa_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        web_d    = 1'b0;
        addr_b_d = addr_b_q;
        data_b_d = data_b_q;
        ovf_d    = ovf_q;
        addr_a   = '0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    i_d     = '0;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = RDA;
                end
            end
            RDA: begin
                addr_a  = AWA'({i_q, 1'b0});
                state_d = RDB;
            end
            RDB: begin
                // A[2i] arrives now, one cycle after its address.
                addr_a  = AWA'({i_q, 1'b1});
                opa_d   = bus.DOutA;
                state_d = ADD;
            end
            ADD: begin
                data_b_d = sum;
                addr_b_d = i_q;
                web_d    = 1'b1;
                if (carry) ovf_d = 1'b1;
                state_d  = WR;
            end
            WR: begin
                if (i_q == AWB'(NB - 1)) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    i_d     = i_q + 1'b1;
                    state_d = RDA;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values; reset is async so WEB drops at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            i_q      <= '0;
            opa_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            web_q    <= 1'b0;
            addr_b_q <= '0;
            data_b_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            opa_q    <= opa_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            web_q    <= web_d;
            addr_b_q <= addr_b_d;
            data_b_q <= data_b_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.AddrA   = addr_a;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.WEB     = web_q;
    assign bus.AddrB   = addr_b_q;
    assign bus.DataInB = data_b_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: doc/mem_xfer_ctrl.md
Name: mem_xfer_ctrl

Overview:
- Transfer controller between 8x8 source memory A and 4x8 target memory B.
- On start, reads A in pairs, adds each pair and writes the sum into B: B[i] = A[2i] + A[2i+1], i = 0..3.
- Drives memory A's read port and memory B's write port.
- Memory B write port: B samples AddrB/DataInB on a posedge with WEB=1.

Parameters:
- DW, 8: data width of both memories.
- NB, 4: number of target words; the source holds 2*NB words.
- AWA, 3: source address width, equal to log2(2*NB).
- AWB, 2: target address width, equal to log2(NB).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a transfer.
- busy  out  1  high from acceptance of start until the DONE state exits.
- done  out  1  one-cycle pulse after the last write.
- AddrA  out  AWA  source read address.
- DOutA  in  DW  source read data. Synchronous: valid the cycle after AddrA is presented.
- AddrB  out  AWB  target address (registered).
- WEB  out  1  target write enable (registered).
- DataInB  out  DW  target write data (registered).
- ovf  out  1  sticky: some pair sum exceeded 2^DW-1. Cleared on start acceptance.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, i=0, busy=0, done=0, WEB=0, AddrB=0, DataInB=0, AddrA=0, ovf=0.
- Reset mid-transfer: aborts immediately; WEB falls asynchronously. B words already written keep their values.
- States: IDLE, RDA, RDB, ADD, WR, DONE. Encoding lives in the package.
- IDLE: AddrA=0. If start=1 at a posedge: i<=0, ovf<=0, busy<=1, go to RDA. Otherwise stay.
- RDA: AddrA=2i (combinational from i). Go to RDB.
- RDB: AddrA=2i+1. DOutA holds A[2i]; latch opA<=DOutA. Go to ADD.
- ADD: DOutA holds A[2i+1].
  - Register DataInB<=f(opA, DOutA), AddrB<=i, WEB<=1.
  - If the DW+1-bit sum has its carry set, ovf<=1.
  - Go to WR.
- WR: WEB=1 for exactly this cycle; B writes at the end of it. WEB<=0.
  - If i==NB-1, go to DONE; else i<=i+1 and go to RDA.
- DONE: done=1 (registered, one cycle), busy still 1, then IDLE with busy<=0. done and busy are 0 in every other state.
- Timing, start sampled at edge k:
  - WEB high in cycles k+4, k+8, k+12, k+16.
  - done high in cycle k+17.
  - busy high cycles k+1..k+17.
  - Total 4*NB+1 cycles.
- start while busy or in DONE: ignored, no restart.
- start in the cycle after DONE: accepted normally.
- Arithmetic: f = low DW bits of opA+DOutA (wrap), unless the optional feature is enabled. The carry always drives ovf.
- AddrB and DataInB hold their last values when WEB=0.
- AddrA outside RDA/RDB: 0.

Optional Feature:
- Macro XFER_SAT_EN.
- Defined: f saturates to 2^DW-1 when the carry is set.
- Undefined: f wraps modulo 2^DW.
- ovf behaviour is identical in both builds.

Decomposition:
- Shared package mem_xfer_pkg:
  - state enumeration/localparams: IDLE=0, RDA=1, RDB=2, ADD=3, WR=4, DONE=5;
  - DW/NB defaults;
  - SRC_WORDS=2*NB.
- One sub-module, xfer_add: combinational DW-bit adder. Outputs sum and carry; XFER_SAT_EN selects saturation.
- Bench instantiates a memory A model with synchronous read and the existing memory B block.

Test Plan:
- Basic: A={1,2,3,4,5,6,7,8}, start pulse -> B={3,7,11,15}; WEB at k+4/8/12/16; done at k+17; ovf=0.
- Overflow wrap (XFER_SAT_EN undefined): A[0]=0xF0, A[1]=0x20, rest 0 -> B[0]=0x10, ovf=1 after the first write and sticky through done.
- Overflow sat (XFER_SAT_EN defined): same stimulus -> B[0]=0xFF, ovf=1. Then A[0..1]=0x01,0x01 and a second start -> ovf cleared at acceptance, B[0]=0x02, ovf=0.
- Start ignored: start pulses at k+5 and k+17 -> single transfer; exactly 4 WEB pulses; done once.
- Reset mid-operation: reset_n low during the second WR cycle (B pre-filled 0xAA) -> WEB/busy drop immediately; B[0] updated, B[2..3]=0xAA; a later start completes normally.
- Back-to-back: start in the cycle after done -> second transfer accepted, identical timing relative to its start.
